// File: rtl/exec_pkg.sv
// Shared decode constants for the execute/memory slice:
// opcodes, function codes, ALU operations and ctrl bit positions.
package exec_pkg;

  localparam int CTRL_W = 19;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_SYS  = 6'h0C;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_ERET = 6'h18;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_MUL  = 4'd11
  } aluop_e;

  localparam int C_RF_DST     = 18;
  localparam int C_RF_WE      = 17;
  localparam int C_BRANCH     = 16;
  localparam int C_JUMP       = 15;
  localparam int C_MEM_WE     = 14;
  localparam int C_MEM_TO_REG = 13;
  localparam int C_ALU_SRC    = 12;
  localparam int C_SHIFT      = 11;
  localparam int C_BRANCH_EQ  = 10;
  localparam int C_BRANCH_LEQ = 9;
  localparam int C_JUMP_REG   = 8;
  localparam int C_JAL        = 7;
  localparam int C_USIGN      = 6;
  localparam int C_SYS        = 5;
  localparam int C_SHIFT_VAR  = 4;
  localparam int C_LOAD_IMM   = 3;
  localparam int C_STORE_HALF = 2;
  localparam int C_EXCE_RET   = 1;
  localparam int C_MEM_WR_ACT = 0;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU with signed 64-bit multiply and compare flags.
// Ports: aluop, x, y in; r1, r2 (MUL high word), eq, leq out.
module exec_alu
  import exec_pkg::*;
(
  input  logic [3:0]  aluop,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic        eq,
  output logic        leq
);

  logic [63:0] xs;
  logic [63:0] ys;
  logic [63:0] prod;
  logic [4:0]  sh;

  // Sign-extend to 64 bits so the low 64 product bits are the signed result.
  assign xs   = {{32{x[31]}}, x};
  assign ys   = {{32{y[31]}}, y};
  assign prod = xs * ys;
  assign sh   = y[4:0];

  always_comb begin
    r1 = '0;
    r2 = '0;
    case (aluop)
      ALU_ADD:  r1 = x + y;
      ALU_SUB:  r1 = x - y;
      ALU_AND:  r1 = x & y;
      ALU_OR:   r1 = x | y;
      ALU_XOR:  r1 = x ^ y;
      ALU_NOR:  r1 = ~(x | y);
      ALU_SLT:  r1 = {31'b0, $signed(x) < $signed(y)};
      ALU_SLTU: r1 = {31'b0, x < y};
      ALU_SLL:  r1 = x << sh;
      ALU_SRL:  r1 = x >> sh;
      ALU_SRA:  r1 = $unsigned($signed(x) >>> sh);
      ALU_MUL: begin
        r1 = prod[31:0];
        r2 = prod[63:32];
      end
      default: ;
    endcase
  end

  assign eq  = (x == y);
  assign leq = ($signed(x) <= $signed(y));

endmodule

// File: rtl/exec_ctrl.sv
// Instruction decoder: op/funct -> ctrl bundle and ALU operation.
// Ports: op, funct in; ctrl (mem_wr_act left 0), aluop out.
module exec_ctrl
  import exec_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        aluop
);

  aluop_e aop;
  logic   r_alu;

  always_comb begin
    ctrl  = '0;
    aop   = ALU_ADD;
    r_alu = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL: begin
            r_alu = 1'b1;
            ctrl[C_SHIFT] = 1'b1;
            aop = ALU_SLL;
          end
          FN_SRL: begin
            r_alu = 1'b1;
            ctrl[C_SHIFT] = 1'b1;
            aop = ALU_SRL;
          end
          FN_SRA: begin
            r_alu = 1'b1;
            ctrl[C_SHIFT] = 1'b1;
            aop = ALU_SRA;
          end
          FN_SLLV: begin
            r_alu = 1'b1;
            ctrl[C_SHIFT] = 1'b1;
            ctrl[C_SHIFT_VAR] = 1'b1;
            aop = ALU_SLL;
          end
          FN_SRLV: begin
            r_alu = 1'b1;
            ctrl[C_SHIFT] = 1'b1;
            ctrl[C_SHIFT_VAR] = 1'b1;
            aop = ALU_SRL;
          end
          FN_SRAV: begin
            r_alu = 1'b1;
            ctrl[C_SHIFT] = 1'b1;
            ctrl[C_SHIFT_VAR] = 1'b1;
            aop = ALU_SRA;
          end
          FN_JR:  ctrl[C_JUMP_REG] = 1'b1;
          FN_SYS: ctrl[C_SYS] = 1'b1;
          FN_ADD, FN_ADDU: r_alu = 1'b1;
          FN_SUB, FN_SUBU: begin
            r_alu = 1'b1;
            aop = ALU_SUB;
          end
          FN_AND: begin
            r_alu = 1'b1;
            aop = ALU_AND;
          end
          FN_OR: begin
            r_alu = 1'b1;
            aop = ALU_OR;
          end
          FN_XOR: begin
            r_alu = 1'b1;
            aop = ALU_XOR;
          end
          FN_NOR: begin
            r_alu = 1'b1;
            aop = ALU_NOR;
          end
          FN_SLT: begin
            r_alu = 1'b1;
            aop = ALU_SLT;
          end
          FN_SLTU: begin
            r_alu = 1'b1;
            aop = ALU_SLTU;
          end
          FN_MULT: begin
            r_alu = 1'b1;
            aop = ALU_MUL;
          end
          default: ;
        endcase
        if (r_alu) begin
          ctrl[C_RF_DST] = 1'b1;
          ctrl[C_RF_WE]  = 1'b1;
        end
      end
      OP_J: ctrl[C_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl[C_JUMP]  = 1'b1;
        ctrl[C_JAL]   = 1'b1;
        ctrl[C_RF_WE] = 1'b1;
      end
      OP_BEQ: begin
        ctrl[C_BRANCH]    = 1'b1;
        ctrl[C_BRANCH_EQ] = 1'b1;
        aop = ALU_SUB;
      end
      OP_BNE: begin
        ctrl[C_BRANCH] = 1'b1;
        aop = ALU_SUB;
      end
      OP_BLEZ: begin
        ctrl[C_BRANCH]     = 1'b1;
        ctrl[C_BRANCH_LEQ] = 1'b1;
        aop = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_RF_WE]   = 1'b1;
      end
      OP_SLTI: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_RF_WE]   = 1'b1;
        aop = ALU_SLT;
      end
      OP_SLTIU: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_RF_WE]   = 1'b1;
        aop = ALU_SLTU;
      end
      OP_ANDI: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_RF_WE]   = 1'b1;
        ctrl[C_USIGN]   = 1'b1;
        aop = ALU_AND;
      end
      OP_ORI: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_RF_WE]   = 1'b1;
        ctrl[C_USIGN]   = 1'b1;
        aop = ALU_OR;
      end
      OP_XORI: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_RF_WE]   = 1'b1;
        ctrl[C_USIGN]   = 1'b1;
        aop = ALU_XOR;
      end
      OP_LUI: begin
        ctrl[C_LOAD_IMM] = 1'b1;
        ctrl[C_RF_WE]    = 1'b1;
      end
      OP_LW: begin
        ctrl[C_ALU_SRC]    = 1'b1;
        ctrl[C_MEM_TO_REG] = 1'b1;
        ctrl[C_RF_WE]      = 1'b1;
      end
      OP_SW: begin
        ctrl[C_ALU_SRC] = 1'b1;
        ctrl[C_MEM_WE]  = 1'b1;
      end
      OP_SH: begin
        ctrl[C_ALU_SRC]    = 1'b1;
        ctrl[C_MEM_WE]     = 1'b1;
        ctrl[C_STORE_HALF] = 1'b1;
      end
      OP_COP0: begin
        if (funct == FN_ERET) ctrl[C_EXCE_RET] = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluop = aop;

endmodule

// File: rtl/exec_dram.sv
// Word RAM with async read, halfword merge and async clear on rst.
// Ports: clk, rst, we, half, hi_sel, waddr, wdata in; rdata out.
module exec_dram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              half,
  input  logic              hi_sel,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] wr_word_d;

  assign rdata = mem_q[waddr];

  // A halfword store keeps the other half of the current word.
  always_comb begin
    wr_word_d = wdata;
    if (half) begin
      wr_word_d = hi_sel ? {wdata[15:0], rdata[15:0]}
                         : {rdata[31:16], wdata[15:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wr_word_d;
    end
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Single-cycle execute/memory slice: decode, operand select, ALU, data RAM.
// Ports: clk, rst, instr, rs/rt data in; ctrl, aluop, ALU results, mem_rdata out.
module exec_mem_unit
  import exec_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        aluop,
  output logic [31:0]       alu_r1,
  output logic [31:0]       alu_r2,
  output logic              alu_eq,
  output logic              alu_leq,
  output logic [31:0]       mem_rdata
);

  logic [CTRL_W-1:0] ctrl_dec;
  logic [31:0]       imm_ext;
  logic [31:0]       alu_x;
  logic [31:0]       alu_y;
  logic              mem_wr_act;
  logic              unused_bits;

  assign unused_bits = ^instr[25:16];

  exec_ctrl u_ctrl (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .ctrl  (ctrl_dec),
    .aluop (aluop)
  );

  assign imm_ext = ctrl_dec[C_USIGN] ? {16'b0, instr[15:0]}
                                     : {{16{instr[15]}}, instr[15:0]};

  assign alu_x = ctrl_dec[C_SHIFT] ? rt_data : rs_data;

  always_comb begin
    alu_y = rt_data;
    if (ctrl_dec[C_SHIFT]) begin
      alu_y = ctrl_dec[C_SHIFT_VAR] ? rs_data : {27'b0, instr[10:6]};
    end else if (ctrl_dec[C_ALU_SRC]) begin
      alu_y = imm_ext;
    end
  end

  exec_alu u_alu (
    .aluop (aluop),
    .x     (alu_x),
    .y     (alu_y),
    .r1    (alu_r1),
    .r2    (alu_r2),
    .eq    (alu_eq),
    .leq   (alu_leq)
  );

  assign mem_wr_act = ctrl_dec[C_MEM_WE] & ~rst;
  assign ctrl = {ctrl_dec[CTRL_W-1:1], mem_wr_act};

  exec_dram #(.ADDR_W(ADDR_W)) u_dram (
    .clk    (clk),
    .rst    (rst),
    .we     (mem_wr_act),
    .half   (ctrl_dec[C_STORE_HALF]),
    .hi_sel (alu_r1[1]),
    .waddr  (alu_r1[ADDR_W+1:2]),
    .wdata  (rt_data),
    .rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: table-driven decode model,
// arithmetic ALU model and array RAM model, random plus directed stimulus.
module tb_exec_mem_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rs_data, rt_data;
  logic [18:0] ctrl;
  logic [3:0]  aluop;
  logic [31:0] alu_r1, alu_r2, mem_rdata;
  logic        alu_eq, alu_leq;

  always #5 clk = ~clk;

  exec_mem_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .ctrl(ctrl), .aluop(aluop),
    .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_eq(alu_eq), .alu_leq(alu_leq),
    .mem_rdata(mem_rdata)
  );

  localparam logic [18:0] M_DST  = 19'd1 << 18;
  localparam logic [18:0] M_WE   = 19'd1 << 17;
  localparam logic [18:0] M_BR   = 19'd1 << 16;
  localparam logic [18:0] M_J    = 19'd1 << 15;
  localparam logic [18:0] M_MWE  = 19'd1 << 14;
  localparam logic [18:0] M_M2R  = 19'd1 << 13;
  localparam logic [18:0] M_SRC  = 19'd1 << 12;
  localparam logic [18:0] M_SH   = 19'd1 << 11;
  localparam logic [18:0] M_BEQ  = 19'd1 << 10;
  localparam logic [18:0] M_BLEQ = 19'd1 << 9;
  localparam logic [18:0] M_JR   = 19'd1 << 8;
  localparam logic [18:0] M_JAL  = 19'd1 << 7;
  localparam logic [18:0] M_US   = 19'd1 << 6;
  localparam logic [18:0] M_SYS  = 19'd1 << 5;
  localparam logic [18:0] M_SV   = 19'd1 << 4;
  localparam logic [18:0] M_LI   = 19'd1 << 3;
  localparam logic [18:0] M_HALF = 19'd1 << 2;
  localparam logic [18:0] M_ERET = 19'd1 << 1;

  typedef struct {
    logic [5:0]  op;
    int          fn;
    logic [18:0] c;
    int          aop;
  } row_t;

  typedef struct {
    logic [18:0] ctrl;
    logic [3:0]  aluop;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        eq;
    logic        leq;
    logic [31:0] rdata;
    int          id;
  } exp_t;

  row_t        tbl[$];
  exp_t        exp_q[$];
  logic [31:0] mm [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_iss = 0;

  function automatic void add(logic [5:0] op, int fn,
                              logic [18:0] c, int aop);
    row_t r;
    r.op = op; r.fn = fn; r.c = c; r.aop = aop;
    tbl.push_back(r);
  endfunction

  function automatic exp_t predict(logic [31:0] i, logic [31:0] a,
                                   logic [31:0] b, logic r);
    exp_t        e;
    logic [18:0] c;
    int          aop, sh;
    logic [31:0] imm, x, y;
    longint      p, sx, m;
    c = '0;
    aop = 0;
    foreach (tbl[k]) begin
      if (tbl[k].op == i[31:26] &&
          (tbl[k].fn < 0 || tbl[k].fn == int'(i[5:0]))) begin
        c = tbl[k].c;
        aop = tbl[k].aop;
      end
    end
    if ((c & M_US) != 0) imm = {16'h0, i[15:0]};
    else imm = {{16{i[15]}}, i[15:0]};
    x = ((c & M_SH) != 0) ? b : a;
    if ((c & M_SH) != 0)
      y = ((c & M_SV) != 0) ? a : 32'(i[10:6]);
    else
      y = ((c & M_SRC) != 0) ? imm : b;
    sh = int'(y % 32);
    p = longint'(1) << sh;
    e.r2 = '0;
    case (aop)
      0: e.r1 = x + y;
      1: e.r1 = x - y;
      2: e.r1 = x & y;
      3: e.r1 = x | y;
      4: e.r1 = x ^ y;
      5: e.r1 = ~(x | y);
      6: e.r1 = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      7: e.r1 = (x < y) ? 32'd1 : 32'd0;
      8: e.r1 = 32'(longint'(x) * p);
      9: e.r1 = 32'(longint'(x) / p);
      10: begin
        sx = longint'($signed(x));
        if (sx >= 0) e.r1 = 32'(sx / p);
        else e.r1 = 32'(-((-sx + p - 1) / p));
      end
      11: begin
        m = longint'($signed(x)) * longint'($signed(y));
        e.r1 = m[31:0];
        e.r2 = m[63:32];
      end
      default: e.r1 = '0;
    endcase
    if ((c & M_MWE) != 0 && !r) c = c | 19'd1;
    e.ctrl  = c;
    e.aluop = 4'(aop);
    e.eq    = (x == y);
    e.leq   = ($signed(x) <= $signed(y));
    e.rdata = mm[(e.r1 >> 2) % DEPTH];
    return e;
  endfunction

  task automatic issue(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    rst = r;
    if (r) foreach (mm[k]) mm[k] = '0;
    instr = i; rs_data = a; rt_data = b;
    e = predict(i, a, b, r);
    e.id = n_iss++;
    exp_q.push_back(e);
    if (e.ctrl[0]) begin
      w = int'((e.r1 >> 2) % DEPTH);
      if ((e.ctrl & M_HALF) != 0) begin
        if (e.r1[1]) mm[w][31:16] = b[15:0];
        else mm[w][15:0] = b[15:0];
      end else begin
        mm[w] = b;
      end
    end
  endtask

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s id=%0d got=%h want=%h", nm, id, got, want);
    end
  endtask

  exp_t em;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      em = exp_q.pop_front();
      chk("ctrl", em.id, 32'(ctrl), 32'(em.ctrl));
      chk("aluop", em.id, 32'(aluop), 32'(em.aluop));
      chk("alu_r1", em.id, alu_r1, em.r1);
      chk("alu_r2", em.id, alu_r2, em.r2);
      chk("eq_leq", em.id, {30'b0, alu_eq, alu_leq},
          {30'b0, em.eq, em.leq});
      chk("mem_rdata", em.id, mem_rdata, em.rdata);
    end
  end

  function automatic logic [31:0] ii(logic [5:0] op, logic [15:0] im);
    return {op, 5'd1, 5'd2, im};
  endfunction

  function automatic logic [31:0] ri(logic [4:0] sa, logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, sa, fn};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 16)) - 32'd8;
      2: return 32'h80000000 >> $urandom_range(0, 1);
      default: return 32'hFFFFFFFF ^ (32'd1 << $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [31:0] i, a, b;
    int          k;
    add(6'h00, 'h00, M_DST|M_WE|M_SH, 8);
    add(6'h00, 'h02, M_DST|M_WE|M_SH, 9);
    add(6'h00, 'h03, M_DST|M_WE|M_SH, 10);
    add(6'h00, 'h04, M_DST|M_WE|M_SH|M_SV, 8);
    add(6'h00, 'h06, M_DST|M_WE|M_SH|M_SV, 9);
    add(6'h00, 'h07, M_DST|M_WE|M_SH|M_SV, 10);
    add(6'h00, 'h08, M_JR, 0);
    add(6'h00, 'h0C, M_SYS, 0);
    add(6'h00, 'h20, M_DST|M_WE, 0);
    add(6'h00, 'h21, M_DST|M_WE, 0);
    add(6'h00, 'h22, M_DST|M_WE, 1);
    add(6'h00, 'h23, M_DST|M_WE, 1);
    add(6'h00, 'h24, M_DST|M_WE, 2);
    add(6'h00, 'h25, M_DST|M_WE, 3);
    add(6'h00, 'h26, M_DST|M_WE, 4);
    add(6'h00, 'h27, M_DST|M_WE, 5);
    add(6'h00, 'h2A, M_DST|M_WE, 6);
    add(6'h00, 'h2B, M_DST|M_WE, 7);
    add(6'h00, 'h18, M_DST|M_WE, 11);
    add(6'h02, -1, M_J, 0);
    add(6'h03, -1, M_J|M_JAL|M_WE, 0);
    add(6'h04, -1, M_BR|M_BEQ, 1);
    add(6'h05, -1, M_BR, 1);
    add(6'h06, -1, M_BR|M_BLEQ, 1);
    add(6'h08, -1, M_SRC|M_WE, 0);
    add(6'h09, -1, M_SRC|M_WE, 0);
    add(6'h0A, -1, M_SRC|M_WE, 6);
    add(6'h0B, -1, M_SRC|M_WE, 7);
    add(6'h0C, -1, M_SRC|M_WE|M_US, 2);
    add(6'h0D, -1, M_SRC|M_WE|M_US, 3);
    add(6'h0E, -1, M_SRC|M_WE|M_US, 4);
    add(6'h0F, -1, M_LI|M_WE, 0);
    add(6'h23, -1, M_SRC|M_M2R|M_WE, 0);
    add(6'h2B, -1, M_SRC|M_MWE, 0);
    add(6'h29, -1, M_SRC|M_MWE|M_HALF, 0);
    add(6'h10, 'h18, M_ERET, 0);
    foreach (mm[j]) mm[j] = '0;

    rst = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    #2 rst = 1'b1;

    // reset state: RAM reads zero, no write strobe
    issue(ii(6'h23, 16'h0004), 32'h100, 32'h0, 1'b1);
    issue(ii(6'h2B, 16'h0004), 32'h100, 32'h55, 1'b1);
    issue(ii(6'h23, 16'h0004), 32'h100, 32'h0, 1'b0);

    issue(ii(6'h08, 16'hFFFF), 32'd5, 32'h0, 1'b0);
    issue(ii(6'h0C, 16'hFFFF), 32'h12345678, 32'h0, 1'b0);
    issue(ri(5'd4, 6'h00), 32'h0, 32'h0000000F, 1'b0);
    issue(ri(5'd0, 6'h07), 32'd4, 32'h80000000, 1'b0);
    issue(ri(5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(ri(5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(ii(6'h04, 16'h0010), 32'd7, 32'd7, 1'b0);
    issue(ii(6'h06, 16'h0010), 32'hFFFFFFFF, 32'h0, 1'b0);
    issue(ri(5'd0, 6'h18), 32'hFFFFFFFD, 32'h7FFFFFFF, 1'b0);
    issue(ii(6'h2B, 16'h0004), 32'h100, 32'hDEADBEEF, 1'b0);
    issue(ii(6'h23, 16'h0004), 32'h100, 32'h0, 1'b0);
    issue(ii(6'h29, 16'h0006), 32'h100, 32'h00001234, 1'b0);
    issue(ii(6'h23, 16'h0004), 32'h100, 32'h0, 1'b0);
    issue(ii(6'h23, 16'h0004), 32'h1100, 32'h0, 1'b0);
    issue(32'hFC000000, 32'h1, 32'h2, 1'b0);
    issue({6'h10, 20'h0, 6'h18}, 32'h1, 32'h2, 1'b0);

    // reset pulse mid-run, with a store edge while reset is high
    issue(ii(6'h23, 16'h0004), 32'h100, 32'h0, 1'b1);
    issue(ii(6'h2B, 16'h0008), 32'h100, 32'hCAFEF00D, 1'b1);
    issue(ii(6'h23, 16'h0008), 32'h100, 32'h0, 1'b0);
    issue(ii(6'h23, 16'h0004), 32'h100, 32'h0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      k = $urandom_range(0, tbl.size());
      i = $urandom;
      a = rnd32();
      b = rnd32();
      if ($urandom_range(0, 3) == 0) b = a;
      if (k < tbl.size()) begin
        i[31:26] = tbl[k].op;
        if (tbl[k].fn >= 0) i[5:0] = 6'(tbl[k].fn);
        if (tbl[k].op == 6'h23 || tbl[k].op == 6'h2B ||
            tbl[k].op == 6'h29) begin
          i[15:0] = 16'($urandom_range(0, 127)) - 16'd64;
          a = 32'h100 + 32'($urandom_range(0, 127));
          if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
        end
      end
      issue(i, a, b, ($urandom_range(0, 59) == 0));
    end

    for (int t = 0; t < 8 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
